// File: rtl/nd_packetizer_pkg.sv
// -----------------------------------------------------------------------------
// nd_packetizer_pkg
//   Shared constants and types for the nd_packetizer framing stage.
//   - HEADER_MARK   : marker byte placed in the top 8 bits of every header word
//   - OVERFLOW_CODE : in-band word emitted once when the sample FIFO overflows
//   - MARK_W/SEQ_W  : header field widths (marker at the MSBs, seq at bit 0)
//   - state_t       : framing FSM encoding
// -----------------------------------------------------------------------------
package nd_packetizer_pkg;

   localparam logic [7:0]  HEADER_MARK   = 8'hA5;
   localparam logic [31:0] OVERFLOW_CODE = 32'hDEAD0F10;

   localparam int MARK_W = 8;
   localparam int SEQ_W  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      BODY   = 3'd2,
      CHECK  = 3'd3,
      OVFL   = 3'd4
   } state_t;

endpackage

// File: rtl/ndp_fifo.sv
// -----------------------------------------------------------------------------
// ndp_fifo
//   Synchronous first-word-fall-through FIFO: data_out always shows the oldest
//   entry, so a pop consumes the word presented in the same cycle.
//   Ports:
//     clk, reset       : clock, asynchronous active-high reset
//     push, din        : write request and data (ignored when full unless a
//                        pop happens in the same cycle)
//     pop              : consume the head entry (ignored when empty)
//     flush            : discard all entries; wins over push/pop
//     data_out         : head entry
//     full, empty      : occupancy flags
// -----------------------------------------------------------------------------
module ndp_fifo #(
   parameter int WDTH      = 32,
   parameter int DEPTH     = 64,
   parameter int LOG_DEPTH = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [WDTH-1:0] din,
   output logic [WDTH-1:0] data_out,
   output logic            full,
   output logic            empty
);

   logic [WDTH-1:0]      mem [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr;
   logic [LOG_DEPTH-1:0] rd_ptr;
   logic [LOG_DEPTH:0]   count;
   logic                 do_push;
   logic                 do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (LOG_DEPTH+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // a full FIFO still accepts a write when the head leaves in the same cycle
   assign do_push  = push && (!full || do_pop);
   assign data_out = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nd_packetizer.sv
// -----------------------------------------------------------------------------
// nd_packetizer
//   Frames the nd-strobed sample stream into packets: every PKT_LEN samples
//   collected in the FIFO are sent as one header word (marker + sequence
//   number) followed by the PKT_LEN samples as a contiguous nd burst. FIFO
//   overflow emits OVERFLOW_CODE in-band and sets the sticky error flag.
//   Optional feature (macro NDP_CHECKSUM_EN): a checksum word (sum of body
//   words mod 2^WDTH) follows each body.
//   Ports:
//     clk       : clock, rising edge
//     reset     : asynchronous active-high reset
//     in_data   : sample word, valid when in_nd=1
//     in_nd     : input new-data strobe
//     out_data  : header, sample, checksum or overflow word
//     out_nd    : out_data valid
//     out_sop   : high with out_nd on header words only
//     error     : sticky overflow flag
// -----------------------------------------------------------------------------
module nd_packetizer
   import nd_packetizer_pkg::*;
#(
   parameter int WDTH           = 32,
   parameter int PKT_LEN        = 16,
   parameter int LOG_PKT_LEN    = 4,
   parameter int FIFO_DEPTH     = 64,
   parameter int LOG_FIFO_DEPTH = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [WDTH-1:0] in_data,
   input  logic            in_nd,
   output logic [WDTH-1:0] out_data,
   output logic            out_nd,
   output logic            out_sop,
   output logic            error
);

   state_t                  state;
   logic [WDTH-1:0]         fifo_dout;
   logic [WDTH-1:0]         header_word;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push;
   logic                    pop;
   logic                    ovfl;
   logic                    pkt_done;
   logic                    last_beat;
   logic                    frame_end;
   logic                    take;
   logic [LOG_PKT_LEN-1:0]  wr_cnt;
   logic [LOG_PKT_LEN-1:0]  body_cnt;
   logic [LOG_FIFO_DEPTH:0] pkts_ready;
   logic [SEQ_W-1:0]        seq;
`ifdef NDP_CHECKSUM_EN
   logic [WDTH-1:0]         sum;

   function automatic logic [WDTH-1:0] wrap_add(input logic [WDTH-1:0] a,
                                                input logic [WDTH-1:0] b);
      return a + b;
   endfunction
`endif

   ndp_fifo #(
      .WDTH      (WDTH),
      .DEPTH     (FIFO_DEPTH),
      .LOG_DEPTH (LOG_FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (ovfl),
      .din      (in_data),
      .data_out (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      pop       = (state == BODY) && !fifo_empty;
      // only a write into a full FIFO with no pop in the same cycle overflows
      ovfl      = in_nd && fifo_full && !pop;
      push      = in_nd && !ovfl;
      pkt_done  = push && (wr_cnt == LOG_PKT_LEN'(PKT_LEN-1));
      last_beat = (body_cnt == LOG_PKT_LEN'(PKT_LEN-1));
      // cycles in which the next header may be scheduled without a gap
`ifdef NDP_CHECKSUM_EN
      frame_end = (state == IDLE) || (state == CHECK);
`else
      frame_end = (state == IDLE) || ((state == BODY) && last_beat);
`endif
      take      = frame_end && (pkts_ready != '0) && !ovfl;

      header_word                   = '0;
      header_word[WDTH-1 -: MARK_W] = HEADER_MARK;
      header_word[SEQ_W-1:0]        = seq;
   end

   // Outputs are registered on the edge that leaves the state naming them:
   // the HEADER state's edge loads the header, each BODY edge loads one word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         out_data   <= '0;
         out_nd     <= 1'b0;
         out_sop    <= 1'b0;
         error      <= 1'b0;
         seq        <= '0;
         pkts_ready <= '0;
         wr_cnt     <= '0;
         body_cnt   <= '0;
`ifdef NDP_CHECKSUM_EN
         sum        <= '0;
`endif
      end else if (ovfl) begin
         // drop the sample, discard everything buffered, report in-band
         wr_cnt     <= '0;
         pkts_ready <= '0;
         error      <= 1'b1;
         state      <= OVFL;
         out_nd     <= 1'b1;
         out_sop    <= 1'b0;
         out_data   <= WDTH'(OVERFLOW_CODE);
      end else begin
         if (push)
            wr_cnt <= wr_cnt + 1'b1;
         if (pkt_done && !take)
            pkts_ready <= pkts_ready + 1'b1;
         else if (!pkt_done && take)
            pkts_ready <= pkts_ready - 1'b1;

         case (state)
            IDLE: begin
               out_nd  <= 1'b0;
               out_sop <= 1'b0;
               if (take)
                  state <= HEADER;
            end
            HEADER: begin
               out_nd   <= 1'b1;
               out_sop  <= 1'b1;
               out_data <= header_word;
               body_cnt <= '0;
`ifdef NDP_CHECKSUM_EN
               sum      <= '0;
`endif
               state    <= BODY;
            end
            BODY: begin
               out_nd   <= 1'b1;
               out_sop  <= 1'b0;
               out_data <= fifo_dout;
               body_cnt <= body_cnt + 1'b1;
`ifdef NDP_CHECKSUM_EN
               sum      <= wrap_add(sum, fifo_dout);
`endif
               if (last_beat) begin
                  seq <= seq + 1'b1;
`ifdef NDP_CHECKSUM_EN
                  state <= CHECK;
`else
                  state <= take ? HEADER : IDLE;
`endif
               end
            end
`ifdef NDP_CHECKSUM_EN
            CHECK: begin
               out_nd   <= 1'b1;
               out_sop  <= 1'b0;
               out_data <= sum;
               state    <= take ? HEADER : IDLE;
            end
`endif
            OVFL: begin
               out_nd  <= 1'b0;
               out_sop <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               out_nd  <= 1'b0;
               out_sop <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
